// File: rtl/image_pipe_pkg.sv
// rtl/image_pipe_pkg.sv - shared image geometry, pixel/coordinate types and scan state
package image_pipe_pkg;

  localparam int IMG_W = 64;
  localparam int IMG_H = 64;
  localparam int AW    = 12;
  localparam int DW    = 13;
  localparam int CW    = 6;

  typedef logic [DW-1:0] pixel_t;
  typedef logic [CW-1:0] coord_t;
  typedef logic [AW-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  // Raster address of pixel (x, y); IMG_W is a power of two so this is {y, x}.
  function automatic addr_t pixel_addr(input coord_t x, input coord_t y);
    return addr_t'(y) * addr_t'(IMG_W) + addr_t'(x);
  endfunction

  // Row below (x, y); the last row clamps onto itself.
  function automatic addr_t bottom_addr(input coord_t x, input coord_t y);
    if (y == coord_t'(IMG_H - 1)) begin
      return pixel_addr(x, y);
    end
    return pixel_addr(x, y + coord_t'(1));
  endfunction

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - x-first raster counter with wrap, look-ahead and last-pixel flag
module raster_counter
  import image_pipe_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clear,
  input  logic   en,
  output coord_t x,
  output coord_t y,
  output coord_t next_x,
  output coord_t next_y,
  output logic   last
);

  logic x_wrap;
  logic y_wrap;

  // Look-ahead of the position after one advance, used for address pre-computation.
  always_comb begin
    x_wrap = (x == coord_t'(IMG_W - 1));
    y_wrap = (y == coord_t'(IMG_H - 1));
    last   = x_wrap && y_wrap;
    next_x = x_wrap ? '0 : x + coord_t'(1);
    next_y = y;
    if (x_wrap) begin
      next_y = y_wrap ? '0 : y + coord_t'(1);
    end
  end

  // Position register: cleared on a new frame, advanced on each enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      x <= next_x;
      y <= next_y;
    end
  end

endmodule

// File: rtl/image_rom_scanner.sv
// rtl/image_rom_scanner.sv - raster scanner of a dual-port image ROM into a vertical pixel-pair stream (option: IMAGE_SCANNER_ZERO_PAD_EN)
module image_rom_scanner
  import image_pipe_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  output logic   busy,
  output logic   done,
  output addr_t  address1,
  output addr_t  address2,
  input  pixel_t data1,
  input  pixel_t data2,
  output logic   out_valid,
  input  logic   out_ready,
  output pixel_t out_top,
  output pixel_t out_bot,
  output coord_t out_x,
  output coord_t out_y,
  output logic   out_last
);

  scan_state_t state;
  coord_t      cnt_x;
  coord_t      cnt_y;
  coord_t      nxt_x;
  coord_t      nxt_y;
  logic        cnt_last;
  logic        start_ok;
  logic        load;
  pixel_t      bot_pixel;

  // A beat is captured whenever fetching and the output slot is empty or draining.
  always_comb begin
    start_ok = (state == IDLE) && start;
    load     = (state == FETCH) && (!out_valid || out_ready);
  end

  raster_counter u_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_ok),
    .en     (load),
    .x      (cnt_x),
    .y      (cnt_y),
    .next_x (nxt_x),
    .next_y (nxt_y),
    .last   (cnt_last)
  );

  // Bottom pixel of the pair: the last row either duplicates itself or pads with zero.
  always_comb begin
`ifdef IMAGE_SCANNER_ZERO_PAD_EN
    bot_pixel = (cnt_y == coord_t'(IMG_H - 1)) ? '0 : data2;
`else
    bot_pixel = data2;
`endif
  end

  // Frame sequencer with registered busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          if (load && cnt_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // ROM addresses track the pixel the next load will capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      address1 <= '0;
      address2 <= '0;
    end else if (start_ok) begin
      address1 <= pixel_addr('0, '0);
      address2 <= bottom_addr('0, '0);
    end else if (load) begin
      address1 <= pixel_addr(nxt_x, nxt_y);
      address2 <= bottom_addr(nxt_x, nxt_y);
    end
  end

  // Output slot: filled on load, emptied on handshake, frozen while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_top   <= '0;
      out_bot   <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_top   <= data1;
      out_bot   <= bot_pixel;
      out_x     <= cnt_x;
      out_y     <= cnt_y;
      out_last  <= cnt_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_image_rom_scanner.sv
// tb/tb_image_rom_scanner.sv - self-checking bench for image_rom_scanner against a raster reference model
module tb_image_rom_scanner;

  localparam int NPIX = 4096;
  localparam int W    = 64;
  localparam int H    = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [11:0] address1;
  logic [11:0] address2;
  logic [12:0] data1;
  logic [12:0] data2;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_top;
  logic [12:0] out_bot;
  logic [5:0]  out_x;
  logic [5:0]  out_y;
  logic        out_last;

  logic [12:0] rom [NPIX];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign data1 = rom[address1];
  assign data2 = rom[address2];

  image_rom_scanner dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .address1  (address1),
    .address2  (address2),
    .data1     (data1),
    .data2     (data2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_top   (out_top),
    .out_bot   (out_bot),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_last  (out_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference pair for beat b in raster order.
  function automatic logic [12:0] ref_top(input int b);
    return rom[b];
  endfunction

  function automatic logic [12:0] ref_bot(input int b);
    int x;
    int y;
    x = b % W;
    y = b / W;
    if (y < H - 1) return rom[(y + 1) * W + x];
`ifdef IMAGE_SCANNER_ZERO_PAD_EN
    return 13'd0;
`else
    return rom[y * W + x];
`endif
  endfunction

  function automatic logic [39:0] ref_beat(input int b);
    int bb;
    bb = b % NPIX;
    return {1'b1, ref_top(bb), ref_bot(bb), 6'(bb % W), 6'(bb / W), (bb == NPIX - 1)};
  endfunction

  // One frame: start, stream, check every handshake and every stall; optionally
  // poke start at beat 100 or assert reset at beat rst_at. done_at is the cycle
  // index of the done pulse counted from the cycle start was high (-1 if none).
  task automatic run_frame(input bit rnd, input bit poke, input int rst_at, input bit ident,
                           output int done_at);
    int          beat;
    int          j;
    bit          held;
    logic [39:0] h_vec;
    logic [39:0] vec;
    beat    = 0;
    held    = 1'b0;
    h_vec   = '0;
    done_at = -1;
    @(negedge clk);
    chk("idle_before_start", 64'(busy), 64'(0));
    start = 1'b1;
    @(posedge clk);
    j = 1;
    while (j < 20000) begin
      #1;
      start     = 1'b0;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      vec = {out_valid, out_top, out_bot, out_x, out_y, out_last};
      if (j == 1) begin
        chk("busy_after_start", 64'(busy), 64'(1));
        chk("no_valid_at_start", 64'(out_valid), 64'(0));
      end
      if (done) begin
        done_at = j;
        chk("beat_count", 64'(beat), 64'(NPIX));
        chk("busy_falls_with_done", 64'(busy), 64'(0));
        break;
      end
      if (held) chk("stall_hold", vec, h_vec);
      held = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          chk("beat", vec, ref_beat(beat));
          if (ident && out_x == 6'd5 && out_y == 6'd2) begin
            chk("pix_5_2_top", 64'(out_top), 64'(133));
            chk("pix_5_2_bot", 64'(out_bot), 64'(197));
          end
          if (ident && out_x == 6'd10 && out_y == 6'd63) begin
            chk("pix_10_63_top", 64'(out_top), 64'(4042));
`ifdef IMAGE_SCANNER_ZERO_PAD_EN
            chk("pix_10_63_bot", 64'(out_bot), 64'(0));
`else
            chk("pix_10_63_bot", 64'(out_bot), 64'(4042));
`endif
          end
          beat++;
          if (poke && beat == 100) start = 1'b1;
          if (rst_at > 0 && beat == rst_at) begin
            #2;
            rst = 1'b1;
            #1;
            chk("async_rst_stream", {out_valid, out_top, out_bot, out_x, out_y, out_last}, 40'd0);
            chk("async_rst_ctrl", {busy, done, address1, address2}, 26'd0);
            @(negedge clk);
            rst     = 1'b0;
            done_at = -2;
            return;
          end
        end else begin
          held  = 1'b1;
          h_vec = vec;
        end
      end
      @(posedge clk);
      j++;
    end
    chk("frame_finished_in_budget", 64'(done_at >= 0), 64'(1));
  endtask

  initial begin
    int d;
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < NPIX; i++) rom[i] = 13'(i % 8192);
    #12;
    chk("reset_stream", {out_valid, out_top, out_bot, out_x, out_y, out_last}, 40'd0);
    chk("reset_ctrl", {busy, done, address1, address2}, 26'd0);
    @(negedge clk);
    rst = 1'b0;

    // Identity ROM, ready held high: full frame and minimum latency.
    run_frame(1'b0, 1'b0, 0, 1'b1, d);
    chk("done_latency_identity", 64'(d), 64'(NPIX + 2));

    // Random ROM content, random backpressure.
    for (int i = 0; i < NPIX; i++) rom[i] = 13'($urandom);
    run_frame(1'b1, 1'b0, 0, 1'b0, d);

    // Start pulsed mid-frame is ignored.
    run_frame(1'b0, 1'b1, 0, 1'b0, d);
    chk("done_latency_start_poke", 64'(d), 64'(NPIX + 2));

    // Asynchronous reset mid-frame, then a clean frame from (0, 0).
    run_frame(1'b1, 1'b0, 1000, 1'b0, d);
    run_frame(1'b0, 1'b0, 0, 1'b0, d);
    chk("done_latency_after_reset", 64'(d), 64'(NPIX + 2));

    // Back-to-back: start in the cycle right after done.
    run_frame(1'b0, 1'b0, 0, 1'b0, d);
    chk("done_latency_back_to_back", 64'(d), 64'(NPIX + 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/image_rom_scanner.md
# image_rom_scanner

Read-side initiator for the dual-port 64x64 image ROM, which has 12-bit addresses, 13-bit data and combinational read. On a start pulse it drives both ROM address ports to scan the frame in raster order. Port 1 fetches row r and port 2 fetches row r+1 of the same column, giving a vertical pixel pair per beat. Pairs are emitted as a valid/ready stream, with coordinates and a frame-last flag, to the 2-row kernel stage downstream.

## Interface
- IMG_W, 64, pixels per row (power of two)
- IMG_H, 64, rows per frame
- AW, 12, ROM address width (log2(IMG_W*IMG_H))
- DW, 13, pixel width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle frame request; ignored unless idle
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last beat is accepted
- address1  out  AW  ROM port 1 address (top row)
- address2  out  AW  ROM port 2 address (bottom row)
- data1  in  DW  ROM port 1 data, combinational from address1
- data2  in  DW  ROM port 2 data, combinational from address2
- out_valid  out  1  pixel pair valid
- out_ready  in  1  downstream accepts
- out_top  out  DW  pixel (x, y)
- out_bot  out  DW  pixel (x, y+1), or boundary value
- out_x  out  6  column of the beat
- out_y  out  6  row of the beat
- out_last  out  1  high on beat (IMG_W-1, IMG_H-1)

## Operation
- States:
  - IDLE → FETCH on start.
  - FETCH → DRAIN when the last address is captured.
  - DRAIN → DONE when the final beat is accepted.
  - DONE → IDLE unconditionally, with done=1 in DONE.
- Scan counters (x, y) start at (0, 0). x increments first and wraps at IMG_W-1, then y increments.
- address1 = y*IMG_W + x.
- address2 = (y+1)*IMG_W + x when y < IMG_H-1. When y = IMG_H-1, address2 = address1 (clamp).
- Load condition: state FETCH and (!out_valid || out_ready).
- On load, the output registers capture data1, data2, x, y and last, and the counters advance.
- Throughput is one pair per cycle under continuous out_ready.
- Output registers hold stable while out_valid && !out_ready (no data change, no counter advance).
- start while busy: ignored, no restart.
- Reset at any point, including mid-frame:
  - state IDLE, counters 0, addresses 0.
  - out_valid=0, out_top/out_bot/out_x/out_y/out_last=0.
  - busy=0, done=0.
- Addresses change only on load or reset.

## Timing
- start sampled at edge N. At edge N the state becomes FETCH with (x, y) = (0, 0) and busy=1.
- First out_valid=1 at edge N+1, carrying pixel (0, 0).
- Beat k is presented no earlier than edge N+1+k.
- Minimum frame time with ready held high: IMG_W*IMG_H + 2 cycles from start to the done pulse.
- done asserts the cycle after the out_last beat handshakes. busy falls with done.
- A new start is accepted in the cycle after done.
- ROM latency is zero: data is sampled in the same cycle the address is presented.

## Configuration
- IMAGE_SCANNER_ZERO_PAD_EN defined: on row IMG_H-1, out_bot = 0 (zero padding). address2 is still driven to address1.
- Undefined: out_bot = data2, which is the clamped duplicate of the last row.

## Structure
- Shared package `image_pipe_pkg` holds:
  - IMG_W, IMG_H, AW, DW constants.
  - pixel_t (DW bits).
  - coord_t (6 bits).
  - scan state enum (IDLE, FETCH, DRAIN, DONE).
- One sub-module, `raster_counter`, provides x/y counting with enable, wrap and last detection. The FSM, address math and output register stay in the top level.

## Test plan
- ROM[i] = i mod 8192, ready always high, one start:
  - 4096 beats; beat (x=5, y=2) gives out_top=133, out_bot=197.
  - out_last only at (63, 63); done at start edge + 4098.
- Last row, macro undefined: beat (10, 63) gives out_top = out_bot = 4042. With IMAGE_SCANNER_ZERO_PAD_EN defined: out_bot = 0.
- out_ready toggling with a pseudo-random 50% pattern:
  - no beat is lost or duplicated, and the sequence matches the raster order.
  - outputs stay stable while valid && !ready.
- start pulsed again at beat 100: ignored, and the frame completes normally with exactly 4096 beats.
- rst asserted asynchronously at beat 1000:
  - all outputs go to 0 immediately.
  - after release, start gives first beat (0, 0) with out_top=ROM[0].
- Back-to-back frames: start in the cycle after done gives a second full frame with identical data.
